// File: rtl/rv32ima_pkg.sv
// Shared types and encodings for the memory arbiter slice: arbiter states,
// load/store width codes and the default wait-state limit.
package rv32ima_pkg;

   typedef logic [31:0] word_t;

   // funct3-style width field; bit 2 (unsigned flag) is irrelevant to lane selection
   localparam int LDST_WIDTH_W = 3;
   localparam logic [1:0] LDST_BYTE = 2'b00;
   localparam logic [1:0] LDST_HALF = 2'b01;
   localparam logic [1:0] LDST_WORD = 2'b10;

   localparam word_t MEM_TIMEOUT_DEFAULT = word_t'(64);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus-side bundle of the arbiter: strobes, word address, lane data and handshake.
interface mem_arbiter_if;
   import rv32ima_pkg::*;

   logic       ren;
   logic       wen;
   word_t      addr;
   word_t      wdata;
   logic [3:0] byte_en;
   word_t      rdata;
   logic       ready;

endinterface

// File: rtl/ldst_lane_align.sv
// Byte-lane steering: byte enables and replicated write data for stores,
// right-justified zero-extended read data for loads.
module ldst_lane_align
   import rv32ima_pkg::*;
(
   input  logic [1:0] width,
   input  logic [1:0] offset,
   input  word_t      store_data,
   input  word_t      rdata,
   output logic [3:0] byte_en,
   output word_t      wdata,
   output word_t      load_data
);

   word_t rshift;

   always_comb begin
      byte_en   = 4'h0;
      wdata     = store_data;
      load_data = '0;
      rshift    = '0;
      case (width)
         LDST_BYTE: begin
            byte_en   = 4'b0001 << offset;
            wdata     = {4{store_data[7:0]}};
            rshift    = rdata >> {offset, 3'b000};
            load_data = rshift & 32'h0000_00FF;
         end
         LDST_HALF: begin
            // halfwords live in lanes 0-1 or 2-3; offset[0] does not move them
            byte_en   = 4'b0011 << {offset[1], 1'b0};
            wdata     = {2{store_data[15:0]}};
            rshift    = rdata >> {offset[1], 4'b0000};
            load_data = rshift & 32'h0000_FFFF;
         end
         LDST_WORD: begin
            byte_en   = 4'hF;
            load_data = rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a single-ported wait-state bus, data has priority.
// Optional wait-state abort is built when MEM_TIMEOUT_EN is defined.
module mem_arbiter
   import rv32ima_pkg::*;
#(
   parameter word_t TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    imem_ren,
   input  logic [31:0]             imem_addr,
   output logic                    ihit,
   output logic [31:0]             imem_load,
   input  logic                    dmem_ren,
   input  logic                    dmem_wen,
   input  logic [31:0]             dmem_addr,
   input  logic [LDST_WIDTH_W-1:0] dmem_width,
   input  logic [31:0]             dmem_store,
   output logic                    dhit,
   output logic [31:0]             dmem_load,
   output logic                    mem_ren,
   output logic                    mem_wen,
   output logic [31:0]             mem_addr,
   output logic [31:0]             mem_wdata,
   output logic [3:0]              mem_byte_en,
   input  logic [31:0]             mem_rdata,
   input  logic                    mem_ready,
   output logic                    bus_err
);

   // state | meaning
   // IDLE  | no bus strobes; arbitrate data over fetch and capture the winner
   // IBUSY | fetch on the bus, held until ready (or abort)
   // DBUSY | load/store on the bus, held until ready (or abort)

   mem_arbiter_if bus ();

   arb_state_t state;
   logic       ren_q, wen_q;
   word_t      addr_q, wdata_q;
   logic [3:0] be_q;
   logic [1:0] width_q, off_q;
   logic       busy, tmo, done;
   logic [1:0] al_width, al_off;
   logic [3:0] al_be;
   word_t      al_wdata, al_load;

   assign busy = (state != IDLE);

   // live request while arbitrating, captured request while the bus returns data
   assign al_width = busy ? width_q : dmem_width[1:0];
   assign al_off   = busy ? off_q   : dmem_addr[1:0];

   ldst_lane_align u_align (
      .width      (al_width),
      .offset     (al_off),
      .store_data (dmem_store),
      .rdata      (bus.rdata),
      .byte_en    (al_be),
      .wdata      (al_wdata),
      .load_data  (al_load)
   );

`ifdef MEM_TIMEOUT_EN
   word_t wait_cnt;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         wait_cnt <= '0;
      else if (!busy)
         wait_cnt <= '0;
      else if (!bus.ready)
         wait_cnt <= wait_cnt + 32'd1;
   end

   assign tmo = busy && !bus.ready && (wait_cnt == TIMEOUT_CYCLES - 32'd1);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign tmo = 1'b0;
`endif

   assign done = bus.ready || tmo;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= IDLE;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= 4'h0;
         width_q <= 2'b00;
         off_q   <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (dmem_ren || dmem_wen) begin
                  state   <= DBUSY;
                  wen_q   <= dmem_wen;
                  ren_q   <= !dmem_wen;
                  addr_q  <= {dmem_addr[31:2], 2'b00};
                  wdata_q <= dmem_wen ? al_wdata : '0;
                  be_q    <= al_be;
                  width_q <= dmem_width[1:0];
                  off_q   <= dmem_addr[1:0];
               end else if (imem_ren) begin
                  state   <= IBUSY;
                  ren_q   <= 1'b1;
                  wen_q   <= 1'b0;
                  addr_q  <= {imem_addr[31:2], 2'b00};
                  wdata_q <= '0;
                  be_q    <= 4'hF;
               end
            end
            IBUSY, DBUSY: begin
               if (done) begin
                  state   <= IDLE;
                  ren_q   <= 1'b0;
                  wen_q   <= 1'b0;
                  addr_q  <= '0;
                  wdata_q <= '0;
                  be_q    <= 4'h0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ren     = ren_q;
   assign bus.wen     = wen_q;
   assign bus.addr    = addr_q;
   assign bus.wdata   = wdata_q;
   assign bus.byte_en = be_q;
   assign bus.rdata   = mem_rdata;
   assign bus.ready   = mem_ready;

   assign mem_ren     = bus.ren;
   assign mem_wen     = bus.wen;
   assign mem_addr    = bus.addr;
   assign mem_wdata   = bus.wdata;
   assign mem_byte_en = bus.byte_en;

   assign ihit      = (state == IBUSY) && done;
   assign dhit      = (state == DBUSY) && done;
   assign bus_err   = tmo;
   assign imem_load = ((state == IBUSY) && bus.ready) ? bus.rdata : '0;
   assign dmem_load = ((state == DBUSY) && bus.ready && !wen_q) ? al_load : '0;

   logic unused_bits;
   assign unused_bits = ^{imem_addr[1:0], dmem_width[LDST_WIDTH_W-1:2]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a datapath driver, a wait-state
// bus responder and a hit monitor checked against a lane-level reference model.
module tb_mem_arbiter;
   import rv32ima_pkg::*;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        nrst;
   logic        imem_ren, dmem_ren, dmem_wen, mem_ready;
   logic [31:0] imem_addr, dmem_addr, dmem_store, mem_rdata;
   logic [2:0]  dmem_width;
   logic        ihit, dhit, mem_ren, mem_wen, bus_err;
   logic [31:0] imem_load, dmem_load, mem_addr, mem_wdata;
   logic [3:0]  mem_byte_en;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .nrst(nrst),
      .imem_ren(imem_ren), .imem_addr(imem_addr), .ihit(ihit), .imem_load(imem_load),
      .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
      .dmem_width(dmem_width), .dmem_store(dmem_store), .dhit(dhit), .dmem_load(dmem_load),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .bus_err(bus_err)
   );

   typedef struct {
      bit          is_data;
      bit          is_store;
      bit          tmo;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] load;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   force_waits = -1;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] m = '0;
      for (int i = 0; i < 4; i++)
         if (be[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   // Reference: lanes and load value from width/offset arithmetic
   function automatic exp_t model_data(input bit st, input logic [31:0] addr, input logic [1:0] w,
                                       input logic [31:0] sd, input logic [31:0] rd);
      exp_t e;
      int off = int'(addr[1:0]);
      int base = off & 2;
      e.is_data = 1; e.is_store = st; e.tmo = 0;
      e.addr = addr & 32'hFFFF_FFFC;
      e.rdata = rd;
      case (w)
         2'd0: begin
            e.be = 4'(1 << off);
            e.wdata = {24'h0, sd[7:0]} * 32'h0101_0101;
            e.load = (rd >> (8 * off)) & 32'hFF;
         end
         2'd1: begin
            e.be = 4'(3 << base);
            e.wdata = {16'h0, sd[15:0]} * 32'h0001_0001;
            e.load = (rd >> (8 * base)) & 32'hFFFF;
         end
         2'd2: begin e.be = 4'hF; e.wdata = sd; e.load = rd; end
         default: begin e.be = 4'h0; e.wdata = 0; e.load = 0; end
      endcase
      if (st) e.load = 0;
      return e;
   endfunction

   // Bus responder: checks the presented transaction, inserts wait states
   initial begin : responder
      bit          in_txn;
      int          wl;
      logic [69:0] snap;
      exp_t        cur;
      in_txn = 0; wl = 0; snap = '0;
      cur = '{default: 0};
      mem_ready = 0; mem_rdata = 0;
      forever begin
         @(posedge clk); #1;
         mem_ready = 0;
         if (!nrst || !(mem_ren || mem_wen)) begin
            in_txn = 0;
         end else begin
            if (!in_txn) begin
               in_txn = 1;
               wl = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
               snap = {mem_ren, mem_wen, mem_addr, mem_wdata, mem_byte_en};
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL bus_unexpected ren=%0b wen=%0b addr=%0h want=none", mem_ren, mem_wen, mem_addr);
                  cur = '{default: 0};
               end else begin
                  cur = exp_q[0];
                  check("bus_strobe", {mem_ren, mem_wen}, {!cur.is_store, cur.is_store});
                  check("bus_addr", mem_addr, cur.addr);
                  check("bus_byte_en", mem_byte_en, cur.be);
                  if (cur.is_store)
                     check("bus_wdata", mem_wdata & lane_mask(cur.be), cur.wdata & lane_mask(cur.be));
               end
            end else begin
               check("bus_stable", {mem_ren, mem_wen, mem_addr, mem_wdata, mem_byte_en}, snap);
            end
            if (wl == 0) begin
               mem_ready = 1; mem_rdata = cur.rdata; in_txn = 0;
            end else begin
               wl--; mem_rdata = $urandom;
            end
         end
      end
   end

   // Hit monitor: pops the scoreboard whenever the datapath sees a completion
   initial begin : monitor
      exp_t e;
      bit   prev_hit;
      prev_hit = 0;
      forever begin
         @(negedge clk);
         if (!nrst) begin
            prev_hit = 0;
         end else begin
            if (prev_hit) check("idle_gap", {mem_ren, mem_wen, ihit, dhit}, 4'b0);
            prev_hit = ihit || dhit;
            if (ihit || dhit) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL hit_unexpected ihit=%0b dhit=%0b want=none", ihit, dhit);
               end else begin
                  e = exp_q.pop_front();
                  check("hit_kind", {ihit, dhit}, {!e.is_data, e.is_data});
                  check("load_data", e.is_data ? dmem_load : imem_load, e.load);
                  check("bus_err", bus_err, e.tmo);
               end
            end else if (bus_err) begin
               total++; bad++;
               $display("FAIL bus_err_alone got=1 want=0");
            end
         end
      end
   end

   // Datapath driver: call at posedge+1 with the arbiter idle; returns at the IDLE gap
   task automatic run_access(input bit do_f, input bit do_d, input bit st,
                             input logic [31:0] iaddr, input logic [31:0] daddr,
                             input logic [31:0] sdata, input logic [2:0] width,
                             input logic [31:0] irdata, input logic [31:0] drdata,
                             input bit withdraw, input bit tmo_exp, output int lat);
      exp_t e;
      bit nd = do_d;
      bit nf = do_f;
      int budget = 0;
      if (do_d) begin
         e = model_data(st, daddr, width[1:0], sdata, drdata);
         if (tmo_exp) begin e.tmo = 1; e.load = 0; end
         exp_q.push_back(e);
      end
      if (do_f) begin
         e.is_data = 0; e.is_store = 0; e.tmo = 0;
         e.addr = iaddr & 32'hFFFF_FFFC; e.be = 4'hF; e.wdata = 0;
         e.rdata = irdata; e.load = irdata;
         exp_q.push_back(e);
      end
      imem_ren = do_f; imem_addr = iaddr;
      dmem_wen = do_d && st;
      dmem_ren = do_d && (!st || ($urandom_range(0, 1) == 1));
      dmem_addr = daddr; dmem_width = width; dmem_store = sdata;
      lat = 0;
      while ((nd || nf) && budget < 100) begin
         @(negedge clk);
         budget++;
         if (dhit) nd = 0;
         if (ihit) nf = 0;
         if (!nd && !nf) lat = budget;
         @(posedge clk); #1;
         if (withdraw && budget == 1) begin
            imem_ren = 0; dmem_ren = 0; dmem_wen = 0;
            imem_addr = $urandom; dmem_addr = $urandom; dmem_store = $urandom;
            dmem_width = 3'($urandom_range(0, 7));
         end
         if (!nd) begin dmem_ren = 0; dmem_wen = 0; end
         if (!nf) imem_ren = 0;
      end
      if (nd || nf) begin
         total++; bad++;
         $display("FAIL access_wait pending_d=%0b pending_f=%0b want=0", nd, nf);
         imem_ren = 0; dmem_ren = 0; dmem_wen = 0;
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog sim_time=%0t want=finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int lat;
      int kind;
      bit st;
      int w;
      bit wd;
      nrst = 0;
      imem_ren = 0; imem_addr = 0; dmem_ren = 0; dmem_wen = 0;
      dmem_addr = 0; dmem_width = 0; dmem_store = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", {ihit, dhit, bus_err, mem_ren, mem_wen, mem_byte_en}, 9'h0);
      check("reset_data", {imem_load, dmem_load, mem_addr, mem_wdata}, 128'h0);
      @(negedge clk) nrst = 1;
      @(posedge clk); #1;

      force_waits = 0;
      run_access(1, 0, 0, 32'h100, 0, 0, 3'b010, 32'h00A0_0093, 0, 0, 0, lat);
      check("fetch_latency", lat, 2);

      force_waits = -1;
      run_access(1, 1, 0, 32'h104, 32'h400, 0, 3'b010, $urandom, $urandom, 0, 0, lat);
      run_access(0, 1, 1, 0, 32'h203, 32'h0000_00AB, 3'b000, 0, $urandom, 0, 0, lat);
      run_access(0, 1, 0, 0, 32'h302, 0, 3'b001, 0, 32'hBEEF_1234, 0, 0, lat);

      force_waits = 5;
      run_access(1, 0, 0, 32'h800, 0, 0, 3'b010, $urandom, 0, 0, 0, lat);
      check("wait5_latency", lat, 7);

      // Reset in the middle of a waited load
      force_waits = 10;
      exp_q.push_back(model_data(0, 32'h500, 2'b10, 0, 32'h1234_5678));
      dmem_ren = 1; dmem_addr = 32'h500; dmem_width = 3'b010;
      repeat (3) @(posedge clk);
      #1;
      nrst = 0;
      #1;
      check("midreset_ctrl", {ihit, dhit, bus_err, mem_ren, mem_wen, mem_byte_en}, 9'h0);
      check("midreset_data", {imem_load, dmem_load, mem_addr, mem_wdata}, 128'h0);
      exp_q.delete();
      dmem_ren = 0;
      @(posedge clk); #1;
      nrst = 1;
      force_waits = 0;
      run_access(1, 0, 0, 32'h600, 0, 0, 3'b010, $urandom, 0, 0, 0, lat);
      check("post_reset_latency", lat, 2);

`ifdef MEM_TIMEOUT_EN
      force_waits = 1000;
      run_access(0, 1, 0, 0, 32'h700, 0, 3'b010, 0, 32'hDEAD_BEEF, 0, 1, lat);
      check("timeout_latency", lat, TMO + 1);
`endif

      force_waits = -1;
      for (int i = 0; i < 300; i++) begin
         kind = int'($urandom_range(0, 2));
         st = 1'($urandom_range(0, 1));
         w = st ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2));
         wd = (kind != 2) && ($urandom_range(0, 3) == 0);
         run_access(kind != 1, kind != 0, st, $urandom, $urandom, $urandom,
                    {1'($urandom_range(0, 1)), 2'(w)}, $urandom, $urandom, wd, 0, lat);
      end

      repeat (4) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the datapath's memory ports.
- Arbitrates the instruction-fetch request (imem_*) and the load/store request (dmem_*) onto one single-ported memory bus with variable wait states.
- Returns ihit/imem_load and dhit/dmem_load to the datapath.
- Performs byte-lane alignment:
  - stores are shifted into the correct lanes with byte enables;
  - loads are right-justified so the datapath's sign/zero extender sees the datum at bit 0.

Parameters:
- TIMEOUT_CYCLES, 64, wait-state limit before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- imem_ren  in  1  instruction fetch request
- imem_addr  in  32  fetch address
- ihit  out  1  fetch complete, one-cycle pulse
- imem_load  out  32  fetched word, valid when ihit
- dmem_ren  in  1  load request
- dmem_wen  in  1  store request
- dmem_addr  in  32  data byte address
- dmem_width  in  LDST_WIDTH_W  bits[1:0]: 00 byte, 01 half, 10 word; upper bit ignored
- dmem_store  in  32  store data, datum in low bits
- dhit  out  1  data access complete, one-cycle pulse
- dmem_load  out  32  load data right-justified, upper bits zero, valid when dhit
- mem_ren  out  1  bus read strobe
- mem_wen  out  1  bus write strobe
- mem_addr  out  32  word-aligned bus address (bits[1:0]=0)
- mem_wdata  out  32  lane-shifted write data
- mem_byte_en  out  4  active byte lanes
- mem_rdata  in  32  bus read data
- mem_ready  in  1  bus completes current access this cycle
- bus_err  out  1  timeout abort pulse (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- FSM states: IDLE, IBUSY, DBUSY.
- Reset value of every output is 0; state is IDLE; capture registers are cleared.
- IDLE:
  - If dmem_ren|dmem_wen, capture the data request and go to DBUSY.
  - Else if imem_ren, capture imem_addr and go to IBUSY.
  - Data has strict priority over fetch.
  - No bus strobes are driven in IDLE.
- Both dmem_wen and dmem_ren set: treated as a store; the read is ignored.
- Bus signals in busy states:
  - mem_* are driven only from the capture registers, never combinationally from datapath inputs.
  - They are held stable until mem_ready.
- IBUSY:
  - mem_ren=1, mem_byte_en=4'hF.
  - On mem_ready: ihit=1, imem_load=mem_rdata in the same cycle; next state IDLE.
- DBUSY:
  - mem_ren or mem_wen per the captured request.
  - On mem_ready: dhit=1; for loads, dmem_load=aligned mem_rdata in the same cycle; next state IDLE.
- Latency: minimum 2 cycles from request to hit (capture cycle, then bus cycle with mem_ready=1). Each wait state adds 1 cycle.
- Back-to-back accesses: one IDLE cycle is always inserted between consecutive accesses, so the datapath sees its request deassert before re-arbitration.
- Alignment (offset = dmem_addr[1:0]):
  - byte: byte_en = 1<<off; wdata = store[7:0] replicated into all lanes; load = rdata >> (8*off), masked to 8 bits.
  - half: byte_en = 2'b11 << off, with off[0] ignored; load masked to 16 bits.
  - word: byte_en = 4'hF.
  - width 11: byte_en = 0 and the bus transaction still completes; misalignment is the datapath's exception responsibility.
- Request withdrawn or changed mid-transaction: the transaction completes on the bus, and hit is still pulsed for the captured request.
- A fetch pending while a data access is in DBUSY waits; it is not lost, because imem_ren is still asserted at the next IDLE.
- Reset asserted mid-transaction: immediately returns to IDLE with all outputs 0. The bus must tolerate strobe drop.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With it defined:
  - A wait counter is cleared on entry to IBUSY/DBUSY and increments each cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES-1 without mem_ready: bus_err=1 for one cycle, ihit/dhit=1 with load data 0, next state IDLE.
- Without it: no counter; the FSM waits indefinitely; bus_err is tied 0.

Decomposition:
- Package rv32ima_pkg:
  - typedef arb_state_t (enum IDLE/IBUSY/DBUSY);
  - ldst width encodings (reuse the existing LDST_WIDTH_W and width codes);
  - a word_t-based constant for the timeout default.
- Sub-module ldst_lane_align (combinational): inputs width, offset, store data, rdata; outputs byte_en, wdata, aligned load.
- Interface mem_arbiter_if bundles the bus side.

Test Plan:
- imem_ren=1, addr=0x100, mem_ready high 1 cycle after strobe, rdata=0x00A00093 -> ihit pulse exactly in cycle 2, imem_load=0x00A00093, mem_byte_en=F.
- dmem_ren and imem_ren raised the same cycle -> DBUSY first, dhit, one IDLE cycle, then IBUSY, ihit; no overlapping strobes.
- byte store 0xAB at addr 0x203 -> mem_addr=0x200, byte_en=1000, wdata[31:24]=0xAB, dhit on ready.
- half load at 0x302 with rdata=0xBEEF1234 -> dmem_load=0x0000BEEF.
- mem_ready held low 5 cycles -> mem_* stable for all 5, hit in the cycle ready rises. nrst pulsed on cycle 3 -> all outputs 0, state IDLE.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready never asserted -> bus_err and dhit pulse 8 cycles after entering DBUSY, dmem_load=0.
